start_validator: RTL

Parametrised start-bit validator for the UART receiver; successor to the single-sample start check. Detects a falling edge on the serial line, majority-votes SAMPLES oversampled points centred on mid-bit, and issues a one-cycle start_valid or start_glitch pulse. After a valid start it holds busy until the data/stop path signals frame completion, so data bits cannot retrigger it.

---
 rtl/start_validator.sv | 104 ++++++++++
 1 files changed

// File: rtl/start_validator.sv
// start_validator: majority-vote UART start-bit check with post-accept busy hold; START_GLITCH_CNT_EN adds a saturating glitch counter
module start_validator #(
  parameter int PRESCALE_W   = 6,
  parameter int SAMPLES      = 3,
  parameter int GLITCH_CNT_W = 8
) (
  input  logic                    clk_stv,
  input  logic                    rst_stv,
  input  logic                    en_stv,
  input  logic                    rx_in_stv,
  input  logic [PRESCALE_W-1:0]   prescale_stv,
  input  logic                    frame_done_stv,
`ifdef START_GLITCH_CNT_EN
  input  logic                    glitch_clr_stv,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_stv,
`endif
  output logic                    start_valid_stv,
  output logic                    start_glitch_stv,
  output logic                    busy_stv,
  output logic [PRESCALE_W-1:0]   edge_cnt_stv
);
  localparam int HALF = SAMPLES / 2;
  localparam int VW = $clog2(SAMPLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT} state_t;
  if (!(SAMPLES == 3 || SAMPLES == 5) || GLITCH_CNT_W < 1) begin : g_bad_param
    $error("start_validator: SAMPLES must be 3 or 5 and GLITCH_CNT_W >= 1");
  end
  state_t                  state;
  logic                    rx_prev;
  logic [VW-1:0]           vote;
  logic [PRESCALE_W-1:0]   presc_q;
  logic                    edge_det, in_win, last_win, vote_ok;
  logic [PRESCALE_W-1:0]   mid, win_lo, win_hi;
  logic [VW-1:0]           vote_nxt;
  always_comb begin
    edge_det = rx_prev && !rx_in_stv && en_stv;
    mid      = presc_q >> 1;
    win_lo   = mid - PRESCALE_W'(HALF);
    win_hi   = mid + PRESCALE_W'(HALF);
    in_win   = edge_cnt_stv >= win_lo && edge_cnt_stv <= win_hi;
    last_win = edge_cnt_stv == win_hi;
    vote_nxt = vote + VW'(!rx_in_stv);
    vote_ok  = vote_nxt > VW'(HALF);
  end
  always_ff @(posedge clk_stv or negedge rst_stv) begin
    if (!rst_stv) begin
      state            <= S_IDLE;
      rx_prev          <= 1'b1;
      vote             <= '0;
      presc_q          <= '0;
      edge_cnt_stv     <= '0;
      busy_stv         <= 1'b0;
      start_valid_stv  <= 1'b0;
      start_glitch_stv <= 1'b0;
    end else begin
      rx_prev          <= rx_in_stv;
      start_valid_stv  <= 1'b0;
      start_glitch_stv <= 1'b0;
      case (state)
        S_IDLE: if (edge_det) begin
          if (prescale_stv >= PRESCALE_W'(SAMPLES + 1)) begin
            state        <= S_CHECK;
            busy_stv     <= 1'b1;
            edge_cnt_stv <= PRESCALE_W'(1);
            vote         <= '0;
            presc_q      <= prescale_stv;
          end else start_glitch_stv <= 1'b1;
        end
        S_CHECK: if (!en_stv) begin
          state        <= S_IDLE;
          busy_stv     <= 1'b0;
          edge_cnt_stv <= '0;
        end else begin
          edge_cnt_stv <= edge_cnt_stv + PRESCALE_W'(1);
          if (in_win) vote <= vote_nxt;
          if (last_win) begin
            state            <= vote_ok ? S_WAIT : S_IDLE;
            busy_stv         <= vote_ok;
            start_valid_stv  <= vote_ok;
            start_glitch_stv <= !vote_ok;
            if (!vote_ok) edge_cnt_stv <= '0;
          end
        end
        S_WAIT: if (!en_stv || frame_done_stv) begin
          state        <= S_IDLE;
          busy_stv     <= 1'b0;
          edge_cnt_stv <= '0;
        end else edge_cnt_stv <= edge_cnt_stv + PRESCALE_W'(1);
        default: begin
          state        <= S_IDLE;
          busy_stv     <= 1'b0;
          edge_cnt_stv <= '0;
        end
      endcase
    end
  end
`ifdef START_GLITCH_CNT_EN
  always_ff @(posedge clk_stv or negedge rst_stv) begin
    if (!rst_stv) glitch_cnt_stv <= '0;
    else glitch_cnt_stv <= glitch_clr_stv ? '0 :
      (start_glitch_stv && glitch_cnt_stv != '1) ? glitch_cnt_stv + GLITCH_CNT_W'(1) : glitch_cnt_stv;
  end
`endif
endmodule
